ex_mem_stage: RTL

- Pipeline stage directly downstream of the ALU.
- Registers the execute-stage result (ALU output, control, store data) into the EX/MEM boundary.
- Owns the architectural flag register, which is fed back to the ALU as its last-flag input.
- Resolves conditional branches against the committed flags and drives a forwarding path for the register-writeback value.

---
 rtl/ex_mem_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary register.
// Latches the execute-stage result and control, owns the architectural {n,v,z} flag register,
// resolves conditional branches against the committed flags and exposes a register-writeback
// forwarding path.
// Optional build macro EX_PERF_CNT_EN adds saturating retired-instruction and bubble counters;
// without it the perf outputs are tied to zero.
module ex_mem_stage #(
  parameter int unsigned DSIZE = 16,
  parameter int unsigned RSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [DSIZE-1:0] alu_out,
  input  logic [2:0]       alu_flag,
  input  logic             ex_flag_we,
  input  logic [RSIZE-1:0] ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_mem_re,
  input  logic             ex_mem_we,
  input  logic [DSIZE-1:0] ex_store_data,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_br_cond,
  input  logic [DSIZE-1:0] ex_br_target,
  output logic             mem_valid,
  output logic [DSIZE-1:0] mem_alu_out,
  output logic [DSIZE-1:0] mem_store_data,
  output logic [RSIZE-1:0] mem_rd,
  output logic             mem_reg_we,
  output logic             mem_mem_re,
  output logic             mem_mem_we,
  output logic [2:0]       last_flag,
  output logic             br_taken,
  output logic [DSIZE-1:0] br_target,
  output logic             fwd_valid,
  output logic [RSIZE-1:0] fwd_rd,
  output logic [DSIZE-1:0] fwd_data,
  output logic [15:0]      perf_instr,
  output logic [15:0]      perf_bubble
);

  logic adv;
  logic cond_met;
  logic br_fire;
  logic flag_n, flag_v, flag_z;

  assign adv = !stall && !flush;
  assign {flag_n, flag_v, flag_z} = last_flag;

  // Branch condition uses committed flags only, never this instruction's alu_flag.
  always_comb begin
    cond_met = 1'b0;
    unique case (ex_br_cond)
      3'b000: cond_met = !flag_z;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = !flag_z && !flag_n;
      3'b011: cond_met = flag_n;
      3'b100: cond_met = !flag_n;
      3'b101: cond_met = flag_z || flag_n;
      3'b110: cond_met = flag_v;
      3'b111: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  assign br_fire = ex_valid && ex_is_branch && cond_met;

  // Pipeline register: flush kills control, stall holds (but drops the redirect pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_alu_out    <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_we     <= 1'b0;
      mem_mem_re     <= 1'b0;
      mem_mem_we     <= 1'b0;
      br_taken       <= 1'b0;
      br_target      <= '0;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_reg_we <= 1'b0;
      mem_mem_re <= 1'b0;
      mem_mem_we <= 1'b0;
      br_taken   <= 1'b0;
    end else if (stall) begin
      br_taken <= 1'b0;
    end else begin
      mem_valid      <= ex_valid;
      mem_alu_out    <= alu_out;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_reg_we     <= ex_valid && ex_reg_we;
      mem_mem_re     <= ex_valid && ex_mem_re;
      mem_mem_we     <= ex_valid && ex_mem_we;
      br_taken       <= br_fire;
      if (br_fire) begin
        br_target <= ex_br_target;
      end
    end
  end

  // Architectural flag register; a flag-writing branch still evaluated against the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_flag <= 3'b000;
    end else if (adv && ex_valid && ex_flag_we) begin
      last_flag <= alu_flag;
    end
  end

  // Loads are not forwarded: their data only exists after the memory access.
  assign fwd_valid = mem_valid && mem_reg_we && !mem_mem_re && (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_out;

`ifdef EX_PERF_CNT_EN
  logic [15:0] perf_instr_q;
  logic [15:0] perf_bubble_q;

  // Saturating counters; a stall edge counts nothing, a flush edge counts as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q  <= 16'd0;
      perf_bubble_q <= 16'd0;
    end else begin
      if (adv && ex_valid && (perf_instr_q != 16'hFFFF)) begin
        perf_instr_q <= perf_instr_q + 16'd1;
      end
      if ((flush || (adv && !ex_valid)) && (perf_bubble_q != 16'hFFFF)) begin
        perf_bubble_q <= perf_bubble_q + 16'd1;
      end
    end
  end

  assign perf_instr  = perf_instr_q;
  assign perf_bubble = perf_bubble_q;
`else
  assign perf_instr  = 16'd0;
  assign perf_bubble = 16'd0;
`endif

endmodule
